// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller driving PC / IF_ID / ID_EX / EX_MEM hold and flush controls
// Ports: reset async active-high; ifIdRs1/ifIdRs2/ifIdUsesRs1/ifIdUsesRs2 describe the IF_ID reader,
// idExMemRead/idExRd describe the ID_EX load; branchTaken from EX; memReq/memReady from MEM;
// clrCnt clears counters; pcWrite/ifIdStall/ifIdFlush/idExStall/idExFlush/exMemStall are pipeline
// controls; stallCycles/flushEvents are saturating performance counters.
module hazard_ctrl #(
  parameter int FLUSH_EXTRA = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifIdRs1,
  input  logic [4:0]       ifIdRs2,
  input  logic             ifIdUsesRs1,
  input  logic             ifIdUsesRs2,
  input  logic             idExMemRead,
  input  logic [4:0]       idExRd,
  input  logic             branchTaken,
  input  logic             memReq,
  input  logic             memReady,
  input  logic             clrCnt,
  output logic             pcWrite,
  output logic             ifIdStall,
  output logic             ifIdFlush,
  output logic             idExStall,
  output logic             idExFlush,
  output logic             exMemStall,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushEvents
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
  localparam logic [2:0] FE = 3'(FLUSH_EXTRA);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic mem_hold, load_use, freeze, br_act, lu_act, in_flush;
  assign mem_hold = memReq & ~memReady;
  assign load_use = idExMemRead & (idExRd != 5'd0) &
                    ((ifIdUsesRs1 & (ifIdRs1 == idExRd)) | (ifIdUsesRs2 & (ifIdRs2 == idExRd)));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  // RUN and MEM_WAIT share the same decision rules; MEM_WAIT only marks an ongoing freeze.
  always_comb begin
    state_d = state_q == FLUSH ? ((mem_hold || cnt_q != 3'd1) ? FLUSH : RUN)
            : mem_hold ? MEM_WAIT
            : (branchTaken && FE != 3'd0) ? FLUSH : RUN;
    cnt_d   = state_q == FLUSH ? (mem_hold ? cnt_q : cnt_q - 3'd1)
            : (!mem_hold && branchTaken) ? FE : cnt_q;
  end
  always_comb begin
    in_flush   = ~reset & (state_q == FLUSH);
    freeze     = ~reset & mem_hold;
    br_act     = ~reset & ~in_flush & ~mem_hold & branchTaken;
    lu_act     = ~reset & ~in_flush & ~mem_hold & ~branchTaken & load_use;
    pcWrite    = ~(freeze | lu_act);
    ifIdStall  = freeze | lu_act;
    ifIdFlush  = in_flush | br_act;
    idExStall  = freeze;
    idExFlush  = br_act | lu_act;
    exMemStall = freeze;
  end
  always_comb begin
    stall_cnt_d = clrCnt ? '0 : (!pcWrite && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = clrCnt ? '0 : (br_act && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
  end
  assign stallCycles = stall_cnt_q;
  assign flushEvents = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int FE = 2;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] ifIdRs1 = '0, ifIdRs2 = '0, idExRd = '0;
  logic ifIdUsesRs1 = 0, ifIdUsesRs2 = 0, idExMemRead = 0, branchTaken = 0;
  logic memReq = 0, memReady = 0, clrCnt = 0;
  logic pcWrite, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall;
  logic [CW-1:0] stallCycles, flushEvents;
  int checks = 0, failures = 0;
  int fl_left = 0, m_stall = 0, m_flush = 0, n_fl = 0, n_stall = 0, n_flush = 0;

  hazard_ctrl #(.FLUSH_EXTRA(FE), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ifIdRs1(ifIdRs1), .ifIdRs2(ifIdRs2),
    .ifIdUsesRs1(ifIdUsesRs1), .ifIdUsesRs2(ifIdUsesRs2), .idExMemRead(idExMemRead),
    .idExRd(idExRd), .branchTaken(branchTaken), .memReq(memReq), .memReady(memReady),
    .clrCnt(clrCnt), .pcWrite(pcWrite), .ifIdStall(ifIdStall), .ifIdFlush(ifIdFlush),
    .idExStall(idExStall), .idExFlush(idExFlush), .exMemStall(exMemStall),
    .stallCycles(stallCycles), .flushEvents(flushEvents)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a pending-flush count plus two saturating integers; a memory wait needs no state
  // of its own because it behaves exactly like RUN once the hold drops.
  always @(negedge clk) begin : model_cmp
    logic mh, lu;
    logic [5:0] e;
    e = 6'b100000;
    n_fl = fl_left; n_stall = m_stall; n_flush = m_flush;
    mh = memReq & ~memReady;
    lu = idExMemRead && idExRd != 0 &&
         ((ifIdUsesRs1 && ifIdRs1 == idExRd) || (ifIdUsesRs2 && ifIdRs2 == idExRd));
    if (reset) begin
      n_fl = 0; n_stall = 0; n_flush = 0;
    end else begin
      if (fl_left > 0) begin
        e = mh ? 6'b011101 : 6'b101000;
        if (!mh) n_fl = fl_left - 1;
      end else if (mh) e = 6'b010101;
      else if (branchTaken) begin
        e = 6'b101010;
        n_fl = FE;
        n_flush = (m_flush == MAXC) ? MAXC : m_flush + 1;
      end else if (lu) e = 6'b010010;
      if (!e[5]) n_stall = (m_stall == MAXC) ? MAXC : m_stall + 1;
      if (clrCnt) begin n_stall = 0; n_flush = 0; end
    end
    chk("ctrl{pc,ifs,iff,ids,idf,exs}",
        {pcWrite, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall}, e);
    chk("stallCycles", stallCycles, m_stall);
    chk("flushEvents", flushEvents, m_flush);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fl_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      fl_left = n_fl; m_stall = n_stall; m_flush = n_flush;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifIdRs1 = 0; ifIdRs2 = 0; idExRd = 0; ifIdUsesRs1 = 0; ifIdUsesRs2 = 0;
    idExMemRead = 0; branchTaken = 0; memReq = 0; memReady = 0; clrCnt = 0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    idExMemRead = 1; idExRd = rd; ifIdRs1 = rd; ifIdUsesRs1 = 1;
  endtask

  initial begin
    idle();
    repeat (2) step();
    reset = 0;
    @(negedge clk);
    chk("lit_reset_pc", pcWrite, 1);
    chk("lit_reset_stallcnt", stallCycles, 0);
    step(); set_lu(5);
    @(negedge clk);
    chk("lit_lu_ctrl", {pcWrite, ifIdStall, idExFlush}, 3'b011);
    step(); idle();
    @(negedge clk);
    chk("lit_lu_stallcnt", stallCycles, 1);
    step(); set_lu(0);
    @(negedge clk);
    chk("lit_lu_rd0_pc", {pcWrite, ifIdStall}, 2'b10);
    step(); idle(); clrCnt = 1;
    step(); clrCnt = 0; branchTaken = 1;
    @(negedge clk);
    chk("lit_br_n", {pcWrite, ifIdFlush, idExFlush}, 3'b111);
    step(); branchTaken = 0;
    @(negedge clk);
    chk("lit_br_n1", {pcWrite, ifIdFlush, idExFlush}, 3'b110);
    chk("lit_br_events", flushEvents, 1);
    step();
    @(negedge clk);
    chk("lit_br_n2", {pcWrite, ifIdFlush, idExFlush}, 3'b110);
    step();
    @(negedge clk);
    chk("lit_br_n3", {pcWrite, ifIdFlush, idExFlush}, 3'b100);
    step(); memReq = 1; memReady = 0; branchTaken = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit_memwait_freeze", {pcWrite, ifIdStall, idExStall, exMemStall, ifIdFlush, idExFlush},
          6'b011100);
      step();
    end
    memReady = 1;
    @(negedge clk);
    chk("lit_memwait_release", {pcWrite, ifIdStall, ifIdFlush, idExFlush, exMemStall}, 5'b10110);
    step(); idle();
    @(negedge clk);
    chk("lit_memwait_stallcnt", stallCycles, 3);
    chk("lit_memwait_events", flushEvents, 2);
    step(); step();
    memReq = 1; branchTaken = 1; set_lu(7);
    @(negedge clk);
    chk("lit_prio", {pcWrite, ifIdFlush, idExFlush, exMemStall}, 4'b0001);
    step(); idle();
    @(negedge clk);
    chk("lit_prio_after", {pcWrite, ifIdFlush, flushEvents}, {2'b10, 4'd2});
    step(); branchTaken = 1;
    step(); branchTaken = 0;
    step(); reset = 1;
    @(negedge clk);
    chk("lit_rst_ctrl", {pcWrite, ifIdFlush, ifIdStall}, 3'b100);
    chk("lit_rst_cnt", {stallCycles, flushEvents}, 0);
    step(); reset = 0;
    @(negedge clk);
    chk("lit_rst_noflush", ifIdFlush, 0);
    step(); set_lu(9);
    repeat (20) step();
    idle();
    @(negedge clk);
    chk("lit_sat", stallCycles, 15);
    clrCnt = 1;
    step(); clrCnt = 0;
    @(negedge clk);
    chk("lit_clr", stallCycles, 0);
    set_lu(3);
    repeat (3) step();
    clrCnt = 1;
    step(); idle();
    @(negedge clk);
    chk("lit_clr_with_stall", stallCycles, 0);
    for (int i = 0; i < 4000; i++) begin
      step();
      reset = ($urandom_range(0, 99) == 0);
      memReq = ($urandom_range(0, 9) < 3);
      memReady = $urandom_range(0, 1);
      branchTaken = ($urandom_range(0, 99) < 15);
      idExMemRead = ($urandom_range(0, 9) < 4);
      idExRd = 5'($urandom_range(0, 3));
      ifIdRs1 = 5'($urandom_range(0, 3));
      ifIdRs2 = 5'($urandom_range(0, 3));
      ifIdUsesRs1 = $urandom_range(0, 1);
      ifIdUsesRs2 = $urandom_range(0, 1);
      clrCnt = ($urandom_range(0, 99) < 2);
    end
    step(); reset = 0; idle();
    step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It is the producer side of the IF_ID stall/flush interface: it drives hold and flush controls into the PC register and the IF_ID, ID_EX and EX_MEM pipeline registers. It detects load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. A small FSM sequences memory wait and extended branch-redirect flushing, and saturating counters record stall cycles and flush events.

Parameters:
FLUSH_EXTRA, 0, number of additional cycles ifIdFlush stays high after the branch-resolution cycle (covers instruction-fetch latency); legal range 0..7
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ifIdRs1  input  5  rs1 field of the instruction in IF_ID
ifIdRs2  input  5  rs2 field of the instruction in IF_ID
ifIdUsesRs1  input  1  instruction in IF_ID reads rs1
ifIdUsesRs2  input  1  instruction in IF_ID reads rs2
idExMemRead  input  1  instruction in ID_EX is a load
idExRd  input  5  destination register of the instruction in ID_EX
branchTaken  input  1  EX resolved a taken branch or jump this cycle
memReq  input  1  MEM stage issues a data-memory access this cycle
memReady  input  1  data memory completes the access this cycle
clrCnt  input  1  synchronous clear of both counters
pcWrite  output  1  0 = PC holds its value
ifIdStall  output  1  IF_ID holds its contents
ifIdFlush  output  1  IF_ID loads zero (NOP)
idExStall  output  1  ID_EX holds its contents
idExFlush  output  1  ID_EX loads a bubble
exMemStall  output  1  EX_MEM holds its contents
stallCycles  output  CNT_W  count of cycles with pcWrite=0, saturating
flushEvents  output  CNT_W  count of taken-branch redirects, saturating

Behaviour:
- Control outputs are combinational from the registered state and the current inputs. Hazards are acted on in the same cycle they are detected.
- Reset (asynchronous): state goes to RUN, flush counter to 0, stallCycles and flushEvents to 0. While reset is high the control outputs are forced to pcWrite=1 and all stall/flush outputs 0.
- Default (no hazard) outputs: pcWrite=1, all stall/flush outputs 0.
- Term definitions:
  - memHold = memReq & ~memReady.
  - loadUse = idExMemRead & (idExRd!=0) & ((ifIdUsesRs1 & ifIdRs1==idExRd) | (ifIdUsesRs2 & ifIdRs2==idExRd)).
- States: RUN, MEM_WAIT, FLUSH.
- RUN, evaluated in priority order:
  1. memHold: pcWrite=0, ifIdStall=1, idExStall=1, exMemStall=1, no flushes; next state MEM_WAIT.
  2. Else branchTaken: ifIdFlush=1, idExFlush=1, pcWrite=1; flushEvents increments. Next state is FLUSH with count=FLUSH_EXTRA if FLUSH_EXTRA>0, otherwise RUN.
  3. Else loadUse: pcWrite=0, ifIdStall=1, idExFlush=1 (one bubble); stays in RUN. The hazard clears the following cycle because the load has moved to EX_MEM.
- MEM_WAIT:
  - While memHold: full freeze as in RUN case 1. branchTaken and loadUse are ignored (their source stages are frozen).
  - On the first cycle memHold=0, evaluate exactly as RUN cases 2 and 3 and take the corresponding transition (RUN or FLUSH).
- FLUSH:
  - memHold takes priority: full freeze plus ifIdFlush=1, the count is not decremented, and the state stays FLUSH.
  - Otherwise: ifIdFlush=1, pcWrite=1, count decrements; when the count reaches 1 and decrements, next state is RUN.
  - branchTaken and loadUse are ignored in FLUSH (ID_EX holds a bubble; IF_ID is being flushed).
- Simultaneous stall and flush on IF_ID never occurs, except in FLUSH with memHold, where flush wins (IF_ID semantics).
- Counters:
  - stallCycles increments each cycle pcWrite=0 (reset inactive).
  - flushEvents increments on each accepted branchTaken.
  - Both saturate at all-ones.
  - clrCnt has priority over increment; the cleared value is 0 on the next edge.
- Reset asserted mid-MEM_WAIT or mid-FLUSH: the FSM returns to RUN immediately, and no residual flush or stall appears after reset deasserts.

Test Plan:
- Load-use: idExMemRead=1, idExRd=5, ifIdRs1=5, ifIdUsesRs1=1 for one cycle → pcWrite=0, ifIdStall=1, idExFlush=1 that cycle; stallCycles=1. Same stimulus with idExRd=0 → no stall.
- Taken branch, FLUSH_EXTRA=2: branchTaken pulse at cycle N → ifIdFlush=1 in cycles N, N+1, N+2, and 0 at N+3; idExFlush=1 only at N; flushEvents=1; pcWrite=1 throughout.
- Memory wait: memReq=1 with memReady=0 for 3 cycles, then memReady=1 → full freeze for 3 cycles, released on the 4th; stallCycles=3; a branchTaken held during the wait is acted on only in the release cycle.
- Priority: memHold, branchTaken and loadUse all true in one RUN cycle → freeze only, no flushes; state becomes MEM_WAIT.
- Reset mid-FLUSH (FLUSH_EXTRA=3, reset asserted on cycle 2 of FLUSH) → outputs return to defaults immediately; counters read 0; no ifIdFlush after reset release.
- Saturation and clear: CNT_W=4, 20 load-use cycles → stallCycles=15; clrCnt pulse → 0 next cycle; clrCnt coinciding with a stall → 0.
